// File: rtl/bram_queue_ctrl.sv
// FIFO controller in front of a 1-cycle-read simple-dual-port BRAM, with a 2-entry FWFT output buffer.
// Optional occupancy statistics (hwm, ovf) are built only when BRAM_QUEUE_STATS_EN is defined.
module bram_queue_ctrl #(
  parameter int DATA_W = 678,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 3)
) (
  input  logic              clka,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              wea,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  input  logic [DATA_W-1:0] doutb
`ifdef BRAM_QUEUE_STATS_EN
  ,
  output logic [CNT_W-1:0]  hwm,
  output logic              ovf
`endif
);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_bram_cnt;
  logic [CNT_W-1:0]  r_count;
  logic              r_inflight;
  logic [1:0]        r_buf_cnt;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;

  logic              w_push;
  logic              w_pop;
  logic              w_rd;
  logic [2:0]        w_occ;

  // A pop in the same cycle deliberately does not free BRAM space: in_ready depends on registers only.
  assign in_ready  = rstn && (r_bram_cnt != CNT_W'(DEPTH));
  assign w_push    = in_valid && in_ready;
  assign out_valid = rstn && (r_buf_cnt != 2'd0);
  assign w_pop     = out_valid && out_ready;

  // Buffer slots already spoken for after this cycle's pop; a new read only goes out if one is left.
  assign w_occ = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd  = rstn && (r_bram_cnt != {CNT_W{1'b0}}) && (w_occ < 3'd2);

  assign count    = r_count;
  assign addra    = r_wr_ptr;
  assign dina     = in_data;
  assign wea      = w_push;
  assign addrb    = r_rd_ptr;
  assign enb      = w_rd;
  assign out_data = r_buf0;

  // Pointers, occupancy counters and the read-in-flight flag.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      r_wr_ptr   <= {ADDR_W{1'b0}};
      r_rd_ptr   <= {ADDR_W{1'b0}};
      r_bram_cnt <= {CNT_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_inflight <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == ADDR_W'(DEPTH - 1)) ? {ADDR_W{1'b0}} : r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == ADDR_W'(DEPTH - 1)) ? {ADDR_W{1'b0}} : r_rd_ptr + ADDR_W'(1);
      end
      r_bram_cnt <= r_bram_cnt + CNT_W'(w_push) - CNT_W'(w_rd);
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_inflight <= w_rd;
    end
  end

  // Output buffer: pop shifts slot 1 to the head in the same edge that returning read data lands.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      r_buf_cnt <= 2'd0;
    end else begin
      case ({w_pop, r_inflight})
        2'b10: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b01: begin
          if (r_buf_cnt == 2'd0) begin
            r_buf0 <= doutb;
          end else begin
            r_buf1 <= doutb;
          end
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= doutb;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= doutb;
          end
        end
        default: begin
          r_buf_cnt <= r_buf_cnt;
        end
      endcase
    end
  end

`ifdef BRAM_QUEUE_STATS_EN
  logic [CNT_W-1:0] r_hwm;
  logic             r_ovf;

  // High-water mark trails count by one cycle; overflow flag is sticky until reset.
  always_ff @(posedge clka) begin
    if (!rstn) begin
      r_hwm <= {CNT_W{1'b0}};
      r_ovf <= 1'b0;
    end else begin
      if (r_count > r_hwm) begin
        r_hwm <= r_count;
      end
      if (in_valid && !in_ready) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign hwm = r_hwm;
  assign ovf = r_ovf;
`endif

endmodule
